bf_key_rx: RTL and testbench
============================

# bf_key_rx

PS/2 keyboard receiver and input queue for the brainfuck CPU's `,` (read) path. It samples the PS/2 clock and data lines and deframes scancodes. It translates make codes to ASCII, buffers them in a FIFO, and answers the CPU's selected-input read request (`data_r_req` with `data_r_sel`=1) with a one-cycle data-enable pulse. It is the input-side counterpart of the top level's LCD output command queue and replaces the raw `key_in`/`key_d_en` pins.

## Interface
- `FIFO_AW`, 4: FIFO address width; depth = 2**FIFO_AW entries.
- `TIMEOUT`, 50000: idle clk cycles mid-frame before the bit counter is abandoned (1 ms at 50 MHz).
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `ps2_clk`  in  1  raw PS/2 clock (asynchronous).
- `ps2_dat`  in  1  raw PS/2 data (asynchronous).
- `rd_req`  in  1  read request pulse from CPU (`data_r_req & data_r_sel`).
- `rd_data`  out  8  ASCII character; valid when `rd_den`=1.
- `rd_den`  out  1  one-cycle data-enable to CPU `data_den`.
- `empty`  out  1  FIFO empty.
- `overflow`  out  1  sticky; set when a character is dropped because the FIFO is full.
- `frame_err`  out  1  one-cycle pulse on a rejected frame.

## Operation
- Sync: `ps2_clk` and `ps2_dat` each pass through 2 flops. A falling edge is synced clk of 1 followed by 0 (third flop). Data is sampled on that cycle.
- Deframer, 11 bits: start (0), 8 data bits LSB first, odd parity, stop (1). A 4-bit counter runs 0..10. At count 10 the frame is checked and the counter returns to 0.
- Frame valid when start=0, stop=1 and parity is odd (see Configuration). Invalid frame -> `frame_err` pulse, byte discarded.
- Timeout: counter ≠0 and TIMEOUT cycles with no falling edge -> counter = 0 and `frame_err` pulses. A partial frame is discarded.
- Decode FSM states IDLE, BREAK, EXT:
  - IDLE: 0xF0 -> BREAK. 0xE0 -> EXT. Mapped code -> push ASCII. Unmapped code -> no push.
  - BREAK: next byte discarded -> IDLE.
  - EXT: 0xF0 -> BREAK. Any other byte discarded -> IDLE.
- Map (set 2, lowercase only):
  - Letters: 0x1C a=0x61, 0x32 b, 0x21 c, 0x23 d, 0x24 e, 0x2B f, 0x34 g, 0x33 h, 0x43 i, 0x3B j, 0x42 k, 0x4B l, 0x3A m, 0x31 n, 0x44 o, 0x4D p, 0x15 q, 0x2D r, 0x1B s, 0x2C t, 0x3C u, 0x2A v, 0x1D w, 0x22 x, 0x35 y, 0x1A z.
  - Digits: 0x45 '0', 0x16 '1', 0x1E '2', 0x26 '3', 0x25 '4', 0x2E '5', 0x36 '6', 0x3D '7', 0x3E '8', 0x46 '9'.
  - Others: 0x29 -> 0x20, 0x5A -> 0x0A, 0x66 -> 0x08.
- FIFO: synchronous, 8 bits wide, read/write pointers of FIFO_AW+1 bits that wrap naturally.
  - Push when full: character dropped, `overflow` set. `overflow` clears only on `rst`.
  - Push and pop in the same cycle while full: both take effect, nothing dropped.
  - Push and pop in the same cycle while empty: the pop waits; the char is delivered next cycle.
- Read handshake:
  - `rd_req` with FIFO non-empty: pop; `rd_data`/`rd_den` are presented the next cycle.
  - `rd_req` with FIFO empty: set `pending`. While `pending`, the first cycle the FIFO is non-empty pops; `rd_den` follows one cycle later and `pending` clears.
  - `rd_req` while `pending` or while the `rd_den` cycle is in flight is ignored. Exactly one `rd_den` is issued per accepted request.
  - `rd_data` holds its last value when `rd_den`=0.

## Timing
- Reset (sync): all sync flops 1; counter 0; FSM IDLE; FIFO empty; `pending` 0; `rd_data` 0x00; `rd_den` 0; `empty` 1; `overflow` 0; `frame_err` 0.
- Stop-bit sample cycle T -> frame check and FSM at T+1 -> FIFO write at T+2 -> `empty` low at T+2 (registered).
- Read latency, non-empty: `rd_req` at cycle R -> `rd_den`=1 at R+1.
- Read latency, pending: push at T+2 -> `rd_den`=1 at T+3.
- `rst` asserted mid-frame or mid-pending: everything returns to reset values next cycle. The outstanding request is dropped, so the CPU must be reset together with this block.

## Configuration
- `BF_KEY_PARITY_EN` defined: odd-parity failure rejects the frame with a `frame_err` pulse.
- Undefined: the parity bit is sampled but ignored; only start and stop bits are checked.

## Test plan
- Send frame 0x1C with good parity, then `rd_req` pulse -> `rd_den`=1 for one cycle, `rd_data`=0x61, `empty`=1 afterwards.
- `rd_req` with FIFO empty, then send 0x16 -> `rd_den` exactly 3 cycles after the stop-bit sample, `rd_data`=0x31. A second `rd_req` while pending produces no extra `rd_den`.
- Send 0x1C, 0xF0, 0x1C (press/release a) -> exactly one entry 0x61. Send 0xE0, 0x75 -> no entry.
- Send frame 0x1C with stop bit 0 -> `frame_err` pulse, no entry. Send a bad-parity frame -> rejected when `BF_KEY_PARITY_EN` is defined, accepted as 0x61 when undefined.
- Send 17 mapped keys with FIFO_AW=4 and no reads -> `overflow`=1 and 16 entries. Reading 16 times returns them in order.
- Send 5 bits then stall TIMEOUT cycles -> `frame_err` pulse. A subsequent full frame 0x29 decodes to 0x20.

Source files
------------

// File: rtl/bf_key_rx.sv
// bf_key_rx: PS/2 receiver, set-2 scancode to ASCII decoder and read FIFO for the CPU input path.
// Define BF_KEY_PARITY_EN to reject frames with bad odd parity; otherwise parity is ignored.
module bf_key_rx #(
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       rd_req,
  output logic [7:0] rd_data,
  output logic       rd_den,
  output logic       empty,
  output logic       overflow,
  output logic       frame_err
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned PW    = FIFO_AW + 1;
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);
  localparam int unsigned FW    = 11;
`ifdef BF_KEY_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BREAK = 2'd1,
    ST_EXT   = 2'd2
  } state_e;

  // Synchronisers; pclk_q[2] is the extra edge-detect flop
  logic [2:0] pclk_q;
  logic [1:0] pdat_q;
  logic       fall_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_q <= '1;
      pdat_q <= '1;
    end else begin
      pclk_q <= {pclk_q[1:0], ps2_clk};
      pdat_q <= {pdat_q[0], ps2_dat};
    end
  end

  assign fall_c = pclk_q[2] & ~pclk_q[1];

  // Deframer: bit counter, shift register and mid-frame idle timeout
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [FW-1:0] shreg_q, shreg_d;
  logic          done_q, done_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          tmo_c;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    done_d    = 1'b0;
    to_cnt_d  = to_cnt_q;
    tmo_c     = 1'b0;
    if (fall_c) begin
      shreg_d  = {pdat_q[1], shreg_q[FW-1:1]};
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        done_d    = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TW'(TIMEOUT - 1)) begin
        tmo_c     = 1'b1;
        bit_cnt_d = 4'd0;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= 4'd0;
      shreg_q   <= '0;
      done_q    <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      done_q    <= done_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // Frame check on the cycle after the stop bit lands
  logic       start_ok_c, stop_ok_c, par_ok_c, frame_ok_c, frame_bad_c;
  logic [7:0] code_c;

  assign start_ok_c  = ~shreg_q[0];
  assign stop_ok_c   = shreg_q[10];
  assign par_ok_c    = (^shreg_q[9:1]) | ~PARITY_EN;
  assign frame_ok_c  = done_q & start_ok_c & stop_ok_c & par_ok_c;
  assign frame_bad_c = done_q & ~(start_ok_c & stop_ok_c & par_ok_c);
  assign code_c      = shreg_q[8:1];

  // Set-2 make code to lowercase ASCII
  logic       map_hit_c;
  logic [7:0] map_char_c;

  always_comb begin
    map_hit_c  = 1'b1;
    map_char_c = 8'h00;
    case (code_c)
      8'h1C: map_char_c = 8'h61;
      8'h32: map_char_c = 8'h62;
      8'h21: map_char_c = 8'h63;
      8'h23: map_char_c = 8'h64;
      8'h24: map_char_c = 8'h65;
      8'h2B: map_char_c = 8'h66;
      8'h34: map_char_c = 8'h67;
      8'h33: map_char_c = 8'h68;
      8'h43: map_char_c = 8'h69;
      8'h3B: map_char_c = 8'h6A;
      8'h42: map_char_c = 8'h6B;
      8'h4B: map_char_c = 8'h6C;
      8'h3A: map_char_c = 8'h6D;
      8'h31: map_char_c = 8'h6E;
      8'h44: map_char_c = 8'h6F;
      8'h4D: map_char_c = 8'h70;
      8'h15: map_char_c = 8'h71;
      8'h2D: map_char_c = 8'h72;
      8'h1B: map_char_c = 8'h73;
      8'h2C: map_char_c = 8'h74;
      8'h3C: map_char_c = 8'h75;
      8'h2A: map_char_c = 8'h76;
      8'h1D: map_char_c = 8'h77;
      8'h22: map_char_c = 8'h78;
      8'h35: map_char_c = 8'h79;
      8'h1A: map_char_c = 8'h7A;
      8'h45: map_char_c = 8'h30;
      8'h16: map_char_c = 8'h31;
      8'h1E: map_char_c = 8'h32;
      8'h26: map_char_c = 8'h33;
      8'h25: map_char_c = 8'h34;
      8'h2E: map_char_c = 8'h35;
      8'h36: map_char_c = 8'h36;
      8'h3D: map_char_c = 8'h37;
      8'h3E: map_char_c = 8'h38;
      8'h46: map_char_c = 8'h39;
      8'h29: map_char_c = 8'h20;
      8'h5A: map_char_c = 8'h0A;
      8'h66: map_char_c = 8'h08;
      default: map_hit_c = 1'b0;
    endcase
  end

  // Decode FSM: tracks break (F0) and extended (E0) prefixes
  state_e state_q, state_d;
  logic   push_c;

  always_comb begin
    state_d = state_q;
    push_c  = 1'b0;
    if (frame_ok_c) begin
      case (state_q)
        ST_IDLE: begin
          if (code_c == 8'hF0)      state_d = ST_BREAK;
          else if (code_c == 8'hE0) state_d = ST_EXT;
          else                      push_c  = map_hit_c;
        end
        ST_BREAK: state_d = ST_IDLE;
        ST_EXT:   state_d = (code_c == 8'hF0) ? ST_BREAK : ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FIFO and read handshake
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          pend_q, pend_d;
  logic          den_q, den_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          full_c, want_c, pop_c, wr_c;
  logic          ferr_q, ferr_d;

  assign full_c = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                  (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);

  always_comb begin
    want_c    = (rd_req & ~pend_q & ~den_q) | pend_q;
    pop_c     = want_c & ~empty_q;
    pend_d    = want_c & empty_q;
    den_d     = pop_c;
    wr_c      = push_c & (~full_c | pop_c);
    ovf_d     = ovf_q | (push_c & full_c & ~pop_c);
    wptr_d    = wr_c ? wptr_q + PW'(1) : wptr_q;
    rptr_d    = pop_c ? rptr_q + PW'(1) : rptr_q;
    empty_d   = (wptr_d == rptr_d);
    rd_data_d = pop_c ? mem_q[rptr_q[FIFO_AW-1:0]] : rd_data_q;
    ferr_d    = frame_bad_c | tmo_c;
  end

  always_ff @(posedge clk) begin
    if (wr_c) mem_q[wptr_q[FIFO_AW-1:0]] <= map_char_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      pend_q    <= 1'b0;
      den_q     <= 1'b0;
      rd_data_q <= 8'h00;
      ferr_q    <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      pend_q    <= pend_d;
      den_q     <= den_d;
      rd_data_q <= rd_data_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_den    = den_q;
  assign empty     = empty_q;
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_bf_key_rx.sv
// Self-checking bench for bf_key_rx: PS/2 frames in, ASCII reads out, checked against a queue model.
module tb_bf_key_rx;

  localparam int unsigned FIFO_AW = 4;
  localparam int unsigned TIMEOUT = 300;
  localparam int unsigned DEPTH   = 16;
`ifdef BF_KEY_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rd_req = 1'b0;
  logic [7:0] rd_data;
  logic       rd_den;
  logic       empty;
  logic       overflow;
  logic       frame_err;

  bf_key_rx #(.FIFO_AW(FIFO_AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .rd_req(rd_req),
    .rd_data(rd_data), .rd_den(rd_den), .empty(empty), .overflow(overflow),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int den_count = 0;
  int unsigned den_last_cyc = 0;
  int ferr_count = 0;
  int unsigned stop_drop_cyc = 0;

  always @(negedge clk) begin
    if (rd_den === 1'b1) begin
      den_count++;
      den_last_cyc = cyc;
    end
    if (frame_err === 1'b1) ferr_count++;
  end

  // Reference model: keyboard layout tables, prefix flags and a bounded character queue
  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] mq [$];
  bit         m_brk = 1'b0;
  bit         m_ext = 1'b0;
  bit         m_ovf = 1'b0;
  int         exp_ferr = 0;

  function automatic logic [8:0] ref_map(input logic [7:0] sc);
    logic [8:0] r;
    r = '0;
    for (int i = 0; i < 26; i++) if (letter_sc[i] == sc) r = {1'b1, 8'(8'h61 + i)};
    for (int i = 0; i < 10; i++) if (digit_sc[i] == sc) r = {1'b1, 8'(8'h30 + i)};
    if (sc == 8'h29) r = {1'b1, 8'h20};
    if (sc == 8'h5A) r = {1'b1, 8'h0A};
    if (sc == 8'h66) r = {1'b1, 8'h08};
    return r;
  endfunction

  task automatic model_rx(input logic [7:0] code, input bit ok);
    logic [8:0] m;
    if (!ok) begin
      exp_ferr++;
      return;
    end
    if (m_brk) m_brk = 1'b0;
    else if (m_ext) begin
      m_ext = 1'b0;
      if (code == 8'hF0) m_brk = 1'b1;
    end else if (code == 8'hF0) m_brk = 1'b1;
    else if (code == 8'hE0) m_ext = 1'b1;
    else begin
      m = ref_map(code);
      if (m[8]) begin
        if (mq.size() < DEPTH) mq.push_back(m[7:0]);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic drive_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) ps2_dat = f[i];
      repeat (3) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) stop_drop_cyc = cyc;
      repeat (4) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_stop, input bit bad_par);
    logic [10:0] f;
    f = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
    drive_bits(f, 11);
    repeat (6) @(negedge clk);
    model_rx(code, !bad_stop && (!PAR_EN || !bad_par));
  endtask

  task automatic do_read(input logic [7:0] exp, input string name);
    @(negedge clk) rd_req = 1'b1;
    @(negedge clk) rd_req = 1'b0;
    checks++;
    if (rd_den !== 1'b1) begin
      errors++; $display("FAIL %s rd_den got %b want 1", name, rd_den);
    end
    checks++;
    if (rd_data !== exp) begin
      errors++; $display("FAIL %s rd_data got %h want %h", name, rd_data, exp);
    end
    @(negedge clk);
    checks++;
    if (rd_den !== 1'b0) begin
      errors++; $display("FAIL %s rd_den_width got %b want 0", name, rd_den);
    end
  endtask

  task automatic drain(input string name);
    while (mq.size() > 0) do_read(mq.pop_front(), name);
    @(negedge clk);
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL %s empty got %b want 1", name, empty);
    end
    checks++;
    if (overflow !== m_ovf) begin
      errors++; $display("FAIL %s overflow got %b want %b", name, overflow, m_ovf);
    end
    checks++;
    if (ferr_count !== exp_ferr) begin
      errors++; $display("FAIL %s frame_err_count got %0d want %0d", name, ferr_count, exp_ferr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_data, rd_den, empty, overflow, frame_err} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset outputs got data=%h den=%b empty=%b ovf=%b ferr=%b want 00 0 1 0 0",
               rd_data, rd_den, empty, overflow, frame_err);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    send_frame(8'h1C, 1'b0, 1'b0);
    checks++;
    if (empty !== 1'b0) begin
      errors++; $display("FAIL basic_not_empty got %b want 0", empty);
    end
    drain("basic");
  endtask

  task automatic test_pending();
    int d0;
    logic [7:0] exp;
    d0 = den_count;
    @(negedge clk) rd_req = 1'b1;
    @(negedge clk) rd_req = 1'b0;
    repeat (5) @(negedge clk);
    @(negedge clk) rd_req = 1'b1;
    @(negedge clk) rd_req = 1'b0;
    checks++;
    if (den_count !== d0) begin
      errors++; $display("FAIL pending_early_den got %0d want %0d", den_count - d0, 0);
    end
    send_frame(8'h16, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    exp = mq.pop_front();
    checks++;
    if (den_count - d0 !== 1) begin
      errors++; $display("FAIL pending_den_count got %0d want 1", den_count - d0);
    end
    checks++;
    if (den_last_cyc !== stop_drop_cyc + 5) begin
      errors++; $display("FAIL pending_latency got %0d want %0d", den_last_cyc, stop_drop_cyc + 5);
    end
    checks++;
    if (rd_data !== exp) begin
      errors++; $display("FAIL pending_data got %h want %h", rd_data, exp);
    end
    drain("pending");
  endtask

  task automatic test_break_ext();
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    checks++;
    if (mq.size() !== 1) begin
      errors++; $display("FAIL break_ext_model_size got %0d want 1", mq.size());
    end
    drain("break_ext");
  endtask

  task automatic test_frame_err();
    send_frame(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    drain("frame_err");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) send_frame(letter_sc[$urandom_range(0, 25)], 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_flag got %b want 1", overflow);
    end
    drain("overflow");
  endtask

  task automatic test_timeout();
    drive_bits(11'h2AA, 5);
    repeat (TIMEOUT - 60) @(negedge clk);
    checks++;
    if (ferr_count !== exp_ferr) begin
      errors++; $display("FAIL timeout_early got %0d want %0d", ferr_count, exp_ferr);
    end
    exp_ferr++;
    repeat (100) @(negedge clk);
    checks++;
    if (ferr_count !== exp_ferr) begin
      errors++; $display("FAIL timeout_fired got %0d want %0d", ferr_count, exp_ferr);
    end
    send_frame(8'h29, 1'b0, 1'b0);
    drain("timeout");
  endtask

  task automatic test_random();
    int r;
    bit bs;
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < 12; j++) begin
        r = $urandom_range(0, 9);
        case (r)
          0, 1, 2: send_frame(letter_sc[$urandom_range(0, 25)], 1'b0, 1'b0);
          3, 4:    send_frame(digit_sc[$urandom_range(0, 9)], 1'b0, 1'b0);
          5:       send_frame(8'h5A, 1'b0, 1'b0);
          6:       send_frame(8'hF0, 1'b0, 1'b0);
          7:       send_frame(8'hE0, 1'b0, 1'b0);
          8:       send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0);
          default: begin
            bs = 1'($urandom_range(0, 1));
            send_frame(letter_sc[$urandom_range(0, 25)], bs, !bs);
          end
        endcase
      end
      drain("random");
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    @(negedge clk) rd_req = 1'b1;
    @(negedge clk) rd_req = 1'b0;
    drive_bits(11'h155, 3);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    mq.delete();
    m_brk = 1'b0;
    m_ext = 1'b0;
    m_ovf = 1'b0;
    d0 = den_count;
    checks++;
    if ({empty, overflow, rd_den} !== 3'b100) begin
      errors++; $display("FAIL reset_mid_state got empty=%b ovf=%b den=%b want 1 0 0", empty, overflow, rd_den);
    end
    send_frame(8'h1C, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (den_count !== d0) begin
      errors++; $display("FAIL reset_mid_pending_dropped got %0d want 0", den_count - d0);
    end
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pending();
    test_break_ext();
    test_frame_err();
    test_overflow();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
